wave_analyzer: RTL

Sample-stream analyser that consumes the 16-bit offset-binary waveform produced by the sine generator and measures it. It detects rising midscale crossings with hysteresis, counts accepted samples per period, and tracks the minimum and maximum sample within each period. Once per completed period it publishes period, min and max with a one-cycle strobe. It sits downstream of the generator/ROM path, for self-check and display of frequency and amplitude.

---
 rtl/wave_pkg.sv | 30 +++
 rtl/hyst_cmp.sv | 18 +
 rtl/wave_analyzer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared types and constants for the wave analyzer: FSM state encoding,
// default sample width / midscale / hysteresis, and threshold arithmetic.
package wave_pkg;

  localparam int          WIDTH_DEF    = 16;
  localparam logic [15:0] MIDSCALE_DEF = 16'h8000;
  localparam logic [15:0] HYST_DEF     = 16'h0100;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARM       = 2'd1,
    S_WAIT_RISE = 2'd2,
    S_MEASURE   = 2'd3
  } wave_state_e;

  // Bit 32 of the result flags underflow of the low threshold; the high
  // threshold is returned unreduced so the caller can test for overflow.
  function automatic logic [32:0] thr_calc(input logic [31:0] mid,
                                           input logic [31:0] hyst,
                                           input logic        high_sel);
    logic [32:0] v;
    if (high_sel) begin
      v = {1'b0, mid} + {1'b0, hyst};
    end else begin
      v = {1'b0, mid} - {1'b0, hyst};
    end
    return v;
  endfunction

endpackage

// File: rtl/hyst_cmp.sv
// Combinational dual-threshold comparator: flags a sample as below the low
// threshold or at/above the high threshold (unsigned).
module hyst_cmp
  import wave_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter logic [WIDTH-1:0] LOW_TH  = '0,
  parameter logic [WIDTH-1:0] HIGH_TH = '0
) (
  input  logic [WIDTH-1:0] sample,
  output logic             is_low,
  output logic             is_high
);

  assign is_low  = (sample <  LOW_TH);
  assign is_high = (sample >= HIGH_TH);

endmodule

// File: rtl/wave_analyzer.sv
// Period / peak analyser for an offset-binary sample stream with hysteretic
// rising-crossing detection. Peak tracking is built only with WAVE_ANALYZER_PEAK_EN.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MIDSCALE = WIDTH'(MIDSCALE_DEF),
  parameter logic [WIDTH-1:0] HYST     = WIDTH'(HYST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] peak_max,
  output logic [WIDTH-1:0] peak_min,
  output logic             meas_valid,
  output logic             no_signal
);

  localparam logic [32:0]      LOW_EXT  = thr_calc(32'(MIDSCALE), 32'(HYST), 1'b0);
  localparam logic [32:0]      HIGH_EXT = thr_calc(32'(MIDSCALE), 32'(HYST), 1'b1);
  localparam logic [WIDTH-1:0] LOW_TH   = LOW_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] HIGH_TH  = HIGH_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  if (LOW_EXT[32] || ((HIGH_EXT >> WIDTH) != 33'd0)) begin : g_bad_thresholds
    $error("wave_analyzer: MIDSCALE +/- HYST leaves the sample range");
  end

  wave_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_low_seen, w_low_seen_nxt;
  logic [WIDTH-1:0] r_period, w_period_nxt;
  logic             r_meas_valid, w_meas_valid_nxt;
  logic             r_no_signal, w_no_signal_nxt;
  logic             w_acc, w_is_low, w_is_high;

  hyst_cmp #(
    .WIDTH  (WIDTH),
    .LOW_TH (LOW_TH),
    .HIGH_TH(HIGH_TH)
  ) u_hyst_cmp (
    .sample (sample),
    .is_low (w_is_low),
    .is_high(w_is_high)
  );

  assign w_acc     = ena & sample_valid;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // Next-state and measurement-update logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_low_seen_nxt   = r_low_seen;
    w_period_nxt     = r_period;
    w_meas_valid_nxt = 1'b0;
    w_no_signal_nxt  = r_no_signal;
    if (!ena) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ARM;
        S_ARM: begin
          if (w_acc && w_is_low) begin
            w_state_nxt = S_WAIT_RISE;
          end else begin
            w_state_nxt = S_ARM;
          end
        end
        S_WAIT_RISE: begin
          if (w_acc && w_is_high) begin
            w_state_nxt    = S_MEASURE;
            w_cnt_nxt      = '0;
            w_low_seen_nxt = 1'b0;
          end else begin
            w_state_nxt = S_WAIT_RISE;
          end
        end
        S_MEASURE: begin
          if (!w_acc) begin
            w_state_nxt = S_MEASURE;
          end else if (w_is_high && r_low_seen) begin
            // Completing crossing takes priority over saturation on the same sample.
            w_period_nxt     = w_cnt_inc;
            w_meas_valid_nxt = 1'b1;
            w_no_signal_nxt  = 1'b0;
            w_cnt_nxt        = '0;
            w_low_seen_nxt   = 1'b0;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_no_signal_nxt = 1'b1;
            w_state_nxt     = S_ARM;
            w_cnt_nxt       = w_cnt_inc;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_low_seen_nxt = r_low_seen | w_is_low;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and published-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_low_seen   <= 1'b0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_no_signal  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_low_seen   <= w_low_seen_nxt;
      r_period     <= w_period_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_no_signal  <= w_no_signal_nxt;
    end
  end

  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign no_signal  = r_no_signal;

`ifdef WAVE_ANALYZER_PEAK_EN
  logic [WIDTH-1:0] r_min, r_max, r_peak_min, r_peak_max;
  logic [WIDTH-1:0] w_min_upd, w_max_upd;
  logic             w_track, w_publish, w_load;

  assign w_track   = w_acc && (r_state == S_MEASURE);
  assign w_publish = w_track && w_is_high && r_low_seen;
  assign w_load    = w_publish || (w_acc && w_is_high && (r_state == S_WAIT_RISE));
  assign w_max_upd = (sample > r_max) ? sample : r_max;
  assign w_min_upd = (sample < r_min) ? sample : r_min;

  // Running min/max of the current period and their published copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min      <= '1;
      r_max      <= '0;
      r_peak_min <= '1;
      r_peak_max <= '0;
    end else begin
      if (w_publish) begin
        r_peak_max <= w_max_upd;
        r_peak_min <= w_min_upd;
      end
      if (w_load) begin
        r_min <= sample;
        r_max <= sample;
      end else if (w_track) begin
        r_min <= w_min_upd;
        r_max <= w_max_upd;
      end
    end
  end

  assign peak_max = r_peak_max;
  assign peak_min = r_peak_min;
`else
  assign peak_max = '0;
  assign peak_min = '0;
`endif

endmodule
